// File: rtl/vga_text_render_if.sv
// Character write channel for vga_text_render.
//   wr_valid : a character byte is offered
//   wr_char  : ASCII byte
//   wr_ready : the renderer can accept a byte this cycle
// A byte transfers on a cycle where wr_valid and wr_ready are both 1.
interface vga_text_render_if;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;

  modport master (output wr_valid, output wr_char, input wr_ready);
  modport slave  (input wr_valid, input wr_char, output wr_ready);
endinterface

// File: rtl/vga_text_render.sv
// 70x30 character text-mode renderer with a scrolling terminal cursor.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   h_addr, v_addr      : current pixel position (640x480 active area)
//   vid_valid           : h_addr/v_addr lie in the active area
//   wr                  : character write channel (slave side)
//   font_ascii/row/col  : lookup presented to an external font ROM
//   font_data           : glyph bit returned combinationally by the ROM
//   vga_r/g/b           : pixel colour, 2 cycles after h_addr/v_addr
//   pix_valid           : vid_valid aligned with the colour outputs
//   cursor_x, cursor_y  : cursor column and logical row
// The buffer is addressed by physical row = (top + logical row) mod 30, so
// scrolling only bumps top and blanks the recycled row.
module vga_text_render (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          h_addr,
  input  logic [9:0]          v_addr,
  input  logic                vid_valid,
  vga_text_render_if.slave    wr,
  output logic [7:0]          font_ascii,
  output logic [3:0]          font_row,
  output logic [3:0]          font_col,
  input  logic                font_data,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                pix_valid,
  output logic [6:0]          cursor_x,
  output logic [4:0]          cursor_y
);

  localparam logic [11:0] LAST_CELL = 12'd2099;
  localparam logic [6:0]  LAST_COL  = 7'd69;
  localparam logic [4:0]  LAST_ROW  = 5'd29;

  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL} state_t;

  state_t      state_reg;
  logic [11:0] clr_idx_reg;
  logic [6:0]  scr_idx_reg;
  logic [4:0]  top_reg;
  logic [6:0]  cur_x_reg;
  logic [4:0]  cur_y_reg;
  logic        wr_ready_reg;

  logic [7:0]  buf_mem [0:2099];

  // Logical (row, col) -> linear buffer address through the wrapping top pointer.
  function automatic logic [11:0] cell_addr(input logic [4:0] top, input logic [4:0] row,
                                            input logic [6:0] col);
    logic [5:0] sum;
    logic [4:0] phys;
    sum  = {1'b0, top} + {1'b0, row};
    phys = (sum >= 6'd30) ? 5'(sum - 6'd30) : sum[4:0];
    return 12'(phys) * 12'd70 + 12'(col);
  endfunction

  // ---------------- write side ----------------
  logic xfer, printable, is_nl, is_bs, do_newline;
  logic       mem_we;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_wdata;

  assign xfer       = wr.wr_valid & wr_ready_reg;
  assign printable  = (wr.wr_char >= 8'h20) && (wr.wr_char <= 8'h7E);
  assign is_nl      = (wr.wr_char == 8'h0A) || (wr.wr_char == 8'h0D);
  assign is_bs      = (wr.wr_char == 8'h08);
  assign do_newline = xfer && ((printable && cur_x_reg == LAST_COL) || is_nl);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 8'h20;
    case (state_reg)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_reg;
      end
      // top has already advanced, so logical row 29 is the recycled oldest row.
      SCROLL: begin
        mem_we    = 1'b1;
        mem_waddr = cell_addr(top_reg, LAST_ROW, scr_idx_reg);
      end
      IDLE: begin
        if (xfer && printable) begin
          mem_we    = 1'b1;
          mem_waddr = cell_addr(top_reg, cur_y_reg, cur_x_reg);
          mem_wdata = wr.wr_char;
        end else if (xfer && is_bs && cur_x_reg != 7'd0) begin
          mem_we    = 1'b1;
          mem_waddr = cell_addr(top_reg, cur_y_reg, cur_x_reg - 7'd1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= CLEAR;
      clr_idx_reg  <= '0;
      scr_idx_reg  <= '0;
      top_reg      <= '0;
      cur_x_reg    <= '0;
      cur_y_reg    <= '0;
      wr_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (clr_idx_reg == LAST_CELL) begin
            clr_idx_reg  <= '0;
            state_reg    <= IDLE;
            wr_ready_reg <= 1'b1;
          end else begin
            clr_idx_reg <= clr_idx_reg + 12'd1;
          end
        end
        SCROLL: begin
          if (scr_idx_reg == LAST_COL) begin
            scr_idx_reg  <= '0;
            state_reg    <= IDLE;
            wr_ready_reg <= 1'b1;
          end else begin
            scr_idx_reg <= scr_idx_reg + 7'd1;
          end
        end
        IDLE: begin
          if (xfer) begin
            if (printable)
              cur_x_reg <= (cur_x_reg == LAST_COL) ? 7'd0 : cur_x_reg + 7'd1;
            else if (is_nl)
              cur_x_reg <= 7'd0;
            else if (is_bs && cur_x_reg != 7'd0)
              cur_x_reg <= cur_x_reg - 7'd1;
          end
          if (do_newline) begin
            if (cur_y_reg < LAST_ROW) begin
              cur_y_reg <= cur_y_reg + 5'd1;
            end else begin
              top_reg      <= (top_reg == LAST_ROW) ? 5'd0 : top_reg + 5'd1;
              scr_idx_reg  <= '0;
              state_reg    <= SCROLL;
              wr_ready_reg <= 1'b0;
            end
          end
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      buf_mem[mem_waddr] <= mem_wdata;
  end

  // ---------------- render side ----------------
  logic [6:0]  char_x;
  logic [4:0]  char_y;
  logic        in_text, rd_ok;
  logic [11:0] rd_addr;

  assign char_x  = 7'(h_addr / 10'd9);
  assign char_y  = v_addr[8:4];
  assign in_text = (h_addr < 10'd630);
  // Outside the 70x30 grid the address is parked at 0 so the read stays in range.
  assign rd_ok   = in_text && !v_addr[9] && (char_y <= LAST_ROW);
  assign rd_addr = rd_ok ? cell_addr(top_reg, char_y, char_x) : 12'd0;

  logic [7:0] char_reg;
  logic [3:0] pix_col_reg, pix_row_reg;
  logic       valid_s0_reg, in_text_reg;
  logic [7:0] colour_reg;
  logic       pix_valid_reg;

  // Registered read with no reset; a same-cycle write returns the old value.
  always_ff @(posedge clk) begin
    char_reg <= buf_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_col_reg   <= '0;
      pix_row_reg   <= '0;
      valid_s0_reg  <= 1'b0;
      in_text_reg   <= 1'b0;
      colour_reg    <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      pix_col_reg   <= 4'(h_addr % 10'd9);
      pix_row_reg   <= v_addr[3:0];
      valid_s0_reg  <= vid_valid;
      in_text_reg   <= in_text;
      colour_reg    <= (font_data && valid_s0_reg && in_text_reg) ? 8'hFF : 8'h00;
      pix_valid_reg <= valid_s0_reg;
    end
  end

  assign font_ascii  = char_reg;
  assign font_row    = pix_row_reg;
  assign font_col    = pix_col_reg;
  assign vga_r       = colour_reg;
  assign vga_g       = colour_reg;
  assign vga_b       = colour_reg;
  assign pix_valid   = pix_valid_reg;
  assign cursor_x    = cur_x_reg;
  assign cursor_y    = cur_y_reg;
  assign wr.wr_ready = wr_ready_reg;

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render: clear timing, cursor wrap, newline,
// backspace, ignored codes, scroll remapping, blanking and reset aborts.
// The font ROM model returns font_ascii[0] (so 'A'=1, space=0) or a forced bit.
module tb_vga_text_render;
  logic       clk;
  logic       rst;
  logic [9:0] h_addr, v_addr;
  logic       vid_valid;
  logic [7:0] font_ascii;
  logic [3:0] font_row, font_col;
  logic       font_data;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       pix_valid;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       font_sel, font_const;

  int vectors     = 0;
  int miscompares = 0;

  vga_text_render_if wr_if();

  vga_text_render dut (
    .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .vid_valid(vid_valid),
    .wr(wr_if), .font_ascii(font_ascii), .font_row(font_row), .font_col(font_col),
    .font_data(font_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  assign font_data = font_sel ? font_const : font_ascii[0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] c);
    int n = 0;
    while (wr_if.wr_ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $error("FAIL put_timeout: observed wr_ready %0b expected 1", wr_if.wr_ready);
    end
    wr_if.wr_valid = 1'b1;
    wr_if.wr_char  = c;
    tick();
    wr_if.wr_valid = 1'b0;
    $display("put byte %02h -> cursor (%0d,%0d)", c, cursor_x, cursor_y);
  endtask

  task automatic check_cell(input int x, input int y, input logic [7:0] exp, input string tag);
    h_addr    = 10'(x * 9);
    v_addr    = 10'(y * 16);
    vid_valid = 1'b1;
    tick();
    chk(tag, 32'(font_ascii), 32'(exp));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (wr_if.wr_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic scan_all(output int bad);
    bad = 0;
    vid_valid = 1'b1;
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 70; x++) begin
        h_addr = 10'(x * 9);
        v_addr = 10'(y * 16);
        tick();
        if (font_ascii !== 8'h20) bad++;
      end
    end
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    h_addr = '0; v_addr = '0; vid_valid = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_char = '0;
    font_sel = 1'b0; font_const = 1'b0;

    // Reset state
    tick();
    chk("rst_wr_ready", 32'(wr_if.wr_ready), 0);
    chk("rst_cursor_x", 32'(cursor_x), 0);
    chk("rst_cursor_y", 32'(cursor_y), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_vga_r", 32'(vga_r), 0);
    rst = 1'b0;

    // Reset in the middle of CLEAR restarts the full 2100-cycle clear
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("clear_cycles", 32'(n), 2100);
    scan_all(bad);
    chk("clear_scan_bad", 32'(bad), 0);

    // 'A' at the cursor, then render timing
    put(8'h41);
    chk("A_cursor_x", 32'(cursor_x), 1);
    h_addr = 10'd4; v_addr = 10'd3; vid_valid = 1'b1;
    tick();
    chk("A_font_ascii", 32'(font_ascii), 32'h41);
    chk("A_font_row", 32'(font_row), 3);
    chk("A_font_col", 32'(font_col), 4);
    tick();
    chk("A_vga_r", 32'(vga_r), 32'hFF);
    chk("A_vga_b", 32'(vga_b), 32'hFF);
    chk("A_pix_valid", 32'(pix_valid), 1);
    h_addr = 10'd17; v_addr = 10'd0;
    tick();
    chk("sp_font_col", 32'(font_col), 8);
    chk("sp_font_ascii", 32'(font_ascii), 32'h20);
    tick();
    chk("sp_vga_g", 32'(vga_g), 0);

    // Line wrap past column 69
    for (int i = 1; i <= 68; i++) put(8'h78);
    chk("fill_cursor_x", 32'(cursor_x), 69);
    put(8'h42);
    chk("wrap_cursor_x", 32'(cursor_x), 0);
    chk("wrap_cursor_y", 32'(cursor_y), 1);
    check_cell(69, 0, 8'h42, "B_at_69_0");
    check_cell(68, 0, 8'h78, "x_at_68_0");
    check_cell(0, 0, 8'h41, "A_at_0_0");

    // Row 1 marker, CR, ignored codes
    put(8'h4D);
    put(8'h0D);
    chk("cr_cursor_x", 32'(cursor_x), 0);
    chk("cr_cursor_y", 32'(cursor_y), 2);
    put(8'h07);
    put(8'h7F);
    chk("ign_cursor_x", 32'(cursor_x), 0);
    chk("ign_cursor_y", 32'(cursor_y), 2);
    check_cell(0, 2, 8'h20, "ign_cell_0_2");

    // Backspace
    repeat (3) put(8'h0A);
    chk("lf_cursor_y", 32'(cursor_y), 5);
    put(8'h08);
    chk("bs0_cursor_x", 32'(cursor_x), 0);
    chk("bs0_cursor_y", 32'(cursor_y), 5);
    check_cell(0, 5, 8'h20, "bs0_cell_0_5");
    put(8'h61); put(8'h62); put(8'h63);
    chk("abc_cursor_x", 32'(cursor_x), 3);
    put(8'h08);
    chk("bs_cursor_x", 32'(cursor_x), 2);
    chk("bs_cursor_y", 32'(cursor_y), 5);
    check_cell(2, 5, 8'h20, "bs_cell_2_5");
    check_cell(1, 5, 8'h62, "b_cell_1_5");

    // Scroll
    repeat (24) put(8'h0A);
    chk("bottom_cursor_y", 32'(cursor_y), 29);
    put(8'h0A);
    wait_ready(n);
    chk("scroll_cycles", 32'(n), 70);
    chk("scroll_cursor_y", 32'(cursor_y), 29);
    chk("scroll_cursor_x", 32'(cursor_x), 0);
    check_cell(0, 0, 8'h4D, "scr_old_row1");
    check_cell(1, 4, 8'h62, "scr_old_row5");
    check_cell(0, 29, 8'h20, "scr_row29_0");
    check_cell(69, 29, 8'h20, "scr_row29_69");
    put(8'h5A);
    check_cell(0, 29, 8'h5A, "Z_at_0_29");
    chk("Z_cursor_x", 32'(cursor_x), 1);

    // Blanking with font forced to 1
    font_sel = 1'b1; font_const = 1'b1;
    h_addr = 10'd0; v_addr = 10'd0; vid_valid = 1'b1;
    tick(); tick();
    chk("force_on_vga_r", 32'(vga_r), 32'hFF);
    h_addr = 10'd635;
    tick(); tick();
    chk("h635_vga_r", 32'(vga_r), 0);
    chk("h635_pix_valid", 32'(pix_valid), 1);
    h_addr = 10'd0; vid_valid = 1'b0;
    tick(); tick();
    chk("novid_vga_b", 32'(vga_b), 0);
    chk("novid_pix_valid", 32'(pix_valid), 0);
    font_sel = 1'b0;

    // Reset during SCROLL aborts and restarts CLEAR
    put(8'h0A);
    repeat (5) tick();
    chk("mid_scroll_ready", 32'(wr_if.wr_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_cursor_y", 32'(cursor_y), 0);
    chk("rst2_cursor_x", 32'(cursor_x), 0);
    wait_ready(n);
    chk("clear2_cycles", 32'(n), 2100);
    scan_all(bad);
    chk("clear2_scan_bad", 32'(bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_text_render.md
VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state rising-edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: h_addr  in  10  current pixel x, 0..639.
REQ-004 SHALL have ports: v_addr  in  10  current pixel y, 0..479.
REQ-005 SHALL have ports: vid_valid  in  1  h_addr/v_addr lie in the active area.
REQ-006 SHALL have ports: wr_valid  in  1  a character byte is offered.
REQ-007 SHALL have ports: wr_char  in  8  ASCII byte.
REQ-008 SHALL have ports: wr_ready  out  1  the block can accept a byte this cycle.
REQ-009 SHALL have ports: font_ascii  out  8  character code sent to the font ROM.
REQ-010 SHALL have ports: font_row  out  4  glyph row, 0..15.
REQ-011 SHALL have ports: font_col  out  4  glyph column, 0..8.
REQ-012 SHALL have ports: font_data  in  1  glyph pixel bit, combinational from the font ROM in the same cycle.
REQ-013 SHALL have ports: vga_r, vga_g, vga_b  out  8 each  pixel colour.
REQ-014 SHALL have ports: pix_valid  out  1  vid_valid delayed to align with the colour outputs.
REQ-015 SHALL have ports: cursor_x  out  7  cursor column, 0..69; cursor_y  out  5  cursor logical row, 0..29.

Function
REQ-016 SHALL hold a 70x30 character buffer (2100 bytes) with one write port and one independent read port.
REQ-017 SHALL address the buffer by physical row = (top + logical row) mod 30, where top is a 5-bit wrapping row pointer.
REQ-018 SHALL implement a state machine with states CLEAR, IDLE and SCROLL.
REQ-019 SHALL write 0x20 (space) to every buffer entry in CLEAR, one entry per cycle (2100 cycles), then enter IDLE.
REQ-020 SHALL drive wr_ready=1 only in IDLE; a byte transfers on a cycle where wr_valid and wr_ready are both 1.
REQ-021 SHALL, on a printable transfer (0x20..0x7E), write the byte at the cursor and advance cursor_x by 1.
REQ-022 SHALL, when cursor_x advances past 69, set cursor_x=0 and apply the newline rule.
REQ-023 SHALL, on a transfer of 0x0A or 0x0D, set cursor_x=0 and apply the newline rule.
REQ-024 Newline rule: if cursor_y<29 then cursor_y+1; else top+1 mod 30, cursor_y stays 29, and the block enters SCROLL.
REQ-025 SHALL, in SCROLL, write 0x20 to the 70 entries of the new logical row 29, one entry per cycle, then return to IDLE; wr_ready=0 for those 70 cycles.
REQ-026 SHALL, on a transfer of 0x08, do nothing if cursor_x=0; otherwise decrement cursor_x and write 0x20 at the new position.
REQ-027 SHALL consume all other byte codes with no buffer or cursor change.
REQ-028 Render stage 0 (combinational): char_x = h_addr/9, pix_col = h_addr mod 9, char_y = v_addr[8:4], pix_row = v_addr[3:0].
REQ-029 Render stage 0 SHALL read the buffer entry at logical (char_x, char_y) into a register.
REQ-030 Render stage 0 SHALL also register pix_col, pix_row, vid_valid and in_text = (h_addr<630).
REQ-031 Render stage 1 SHALL drive font_ascii, font_row and font_col from the stage-0 registers.
REQ-032 Render stage 1 SHALL register colour 0xFF on all three channels when font_data=1, vid_valid=1 and in_text=1; otherwise 0x00.
REQ-033 SHALL give a total latency of 2 cycles from h_addr/v_addr/vid_valid to vga_*/pix_valid.
REQ-034 SHALL let rendering run in every state; a write and a render read to the same entry in one cycle render the old value.
REQ-035 SHALL render columns 630..639 black.

Reset
REQ-036 SHALL, when rst=1, enter CLEAR at clear index 0 with cursor_x=0, cursor_y=0, top=0, wr_ready=0, vga_*=0 and pix_valid=0.
REQ-037 SHALL, if rst is asserted during SCROLL or CLEAR, abort that operation and restart CLEAR from index 0.
REQ-038 Render pipeline registers SHALL resume on the first cycle after rst deasserts.

Verification
REQ-039 Reset: hold rst for 1 cycle and release -> wr_ready=0 for exactly 2100 cycles, then 1; every entry reads 0x20.
REQ-040 Write 'A' (0x41) at the cursor; drive h_addr=0, v_addr=0 -> font_ascii=0x41 one cycle later; vga_* show the glyph bits two cycles later.
REQ-041 From cursor (69,0), write 'B' -> 'B' stored at (69,0); cursor moves to (0,1).
REQ-042 At cursor_y=29, write 0x0A -> top increments by 1, wr_ready=0 for 70 cycles, and old row 1 now renders at v_addr=0..15.
REQ-043 Backspace at (0,5) -> no change; at (3,5) -> cursor (2,5) and 0x20 written at (2,5).
REQ-044 With a font_data model returning 1, drive h_addr=635 or vid_valid=0 -> vga_*=0x00 two cycles later.
